// File: rtl/demod_avg_decim.sv
// Boxcar average over the last 2^LOG2_LEN accepted samples with runtime decimation.
// One registered stage: accepted sample at edge k updates dout/dout_valid at edge k.
module demod_avg_decim #(
  parameter int DATA_WIDTH  = 12,
  parameter int LOG2_LEN    = 4,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                         clk_in,
  input  logic                         RST,
  input  logic [DECIM_WIDTH-1:0]       DECIM,
  input  logic                         din_valid,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic                         filled
);

  localparam int N      = 1 << LOG2_LEN;
  localparam int ACC_W  = DATA_WIDTH + LOG2_LEN;
  localparam int FILL_W = LOG2_LEN + 1;

  // Window mean, floor rounding; N-sample sums of DATA_WIDTH values always fit back.
  function automatic logic signed [DATA_WIDTH-1:0] avg_out(input logic signed [ACC_W-1:0] s);
    avg_out = DATA_WIDTH'(s >>> LOG2_LEN);
  endfunction

  function automatic logic [DECIM_WIDTH-1:0] eff_decim(input logic [DECIM_WIDTH-1:0] d);
    eff_decim = (d == '0) ? DECIM_WIDTH'(1) : d;
  endfunction

  logic signed [DATA_WIDTH-1:0] r_buf [N];
  logic [LOG2_LEN-1:0]          r_wr_ptr;
  logic signed [ACC_W-1:0]      r_acc;
  logic [FILL_W-1:0]            r_fill_cnt;
  logic                         r_filled;
  logic [DECIM_WIDTH-1:0]       r_decim_r;
  logic [DECIM_WIDTH-1:0]       r_decim_cnt;
  logic signed [DATA_WIDTH-1:0] r_dout_p1;
  logic                         r_vld_p1;

  logic signed [DATA_WIDTH-1:0] w_old;
  logic signed [ACC_W-1:0]      w_new_acc;
  logic                         w_last_fill;
  logic                         w_slot_end;
  logic                         w_emit;

  assign w_old       = r_buf[r_wr_ptr];
  assign w_new_acc   = r_acc + ACC_W'(din) - ACC_W'(w_old);
  assign w_last_fill = (r_fill_cnt == FILL_W'(N - 1));
  assign w_slot_end  = (r_decim_cnt == (r_decim_r - DECIM_WIDTH'(1)));
  // The sample completing the first window always emits, whatever the slot count.
  assign w_emit      = din_valid && (r_filled ? w_slot_end : w_last_fill);

  // Stage p1: window update, fill tracking, decimation and output registers
  always_ff @(posedge clk_in) begin
    if (RST) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_wr_ptr    <= '0;
      r_acc       <= '0;
      r_fill_cnt  <= '0;
      r_filled    <= 1'b0;
      r_decim_r   <= eff_decim(DECIM);
      r_decim_cnt <= '0;
      r_dout_p1   <= '0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= w_emit;
      if (din_valid) begin
        r_buf[r_wr_ptr] <= din;
        r_acc           <= w_new_acc;
        r_wr_ptr        <= r_wr_ptr + LOG2_LEN'(1);
        if (!r_filled) begin
          r_fill_cnt <= r_fill_cnt + FILL_W'(1);
          if (w_last_fill) r_filled <= 1'b1;
        end
        if (w_emit) begin
          r_dout_p1   <= avg_out(w_new_acc);
          r_decim_cnt <= '0;
          r_decim_r   <= eff_decim(DECIM);
        end else if (r_filled) begin
          r_decim_cnt <= r_decim_cnt + DECIM_WIDTH'(1);
        end
      end
    end
  end

  assign dout       = r_dout_p1;
  assign dout_valid = r_vld_p1;
  assign filled     = r_filled;

endmodule

// File: tb/tb_demod_avg_decim.sv
// Directed bench for demod_avg_decim: N=16 instance plus an N=4 instance for rounding cases.
module tb_demod_avg_decim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_a = 1'b1, vld_a = 1'b0, dv_a, filled_a;
  logic [7:0]          decim_a = 8'd1;
  logic signed [11:0]  din_a = '0, dout_a;
  logic                rst_b = 1'b1, vld_b = 1'b0, dv_b, filled_b;
  logic [7:0]          decim_b = 8'd1;
  logic signed [11:0]  din_b = '0, dout_b;

  demod_avg_decim #(.DATA_WIDTH(12), .LOG2_LEN(4), .DECIM_WIDTH(8)) u_a (
    .clk_in(clk), .RST(rst_a), .DECIM(decim_a), .din_valid(vld_a), .din(din_a),
    .dout(dout_a), .dout_valid(dv_a), .filled(filled_a));

  demod_avg_decim #(.DATA_WIDTH(12), .LOG2_LEN(2), .DECIM_WIDTH(8)) u_b (
    .clk_in(clk), .RST(rst_b), .DECIM(decim_b), .din_valid(vld_b), .din(din_b),
    .dout(dout_b), .dout_valid(dv_b), .filled(filled_b));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic signed [11:0] din;
    logic               v;
    logic signed [11:0] d;
    logic               f;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic signed [11:0] d);
    vld_a = v; din_a = d;
    @(posedge clk); #1;
    vld_a = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1; vld_a = 1'b1; din_a = 12'sd999;
    @(posedge clk); #1;
    rst_a = 1'b0; vld_a = 1'b0;
  endtask

  task automatic run_seq(input bit gapped);
    logic signed [31:0] hold;
    bit                 ev;
    decim_a = 8'd1;
    reset_a();
    hold = 0;
    for (int j = 1; j <= 28; j++) begin
      if (j == 19) decim_a = 8'd3;
      if (gapped) begin
        repeat ($urandom_range(0, 3)) begin
          step_a(1'b0, 12'sd0);
          chk("seq_idle_vld", {31'd0, dv_a}, 0);
        end
      end
      step_a(1'b1, 12'(j - 1));
      ev = (j == 16) || (j == 17) || (j == 18) || (j == 19) || (j == 22) || (j == 25) || (j == 28);
      if (ev) hold = j - 9;
      chk(gapped ? "gap_vld" : "seq_vld", {31'd0, dv_a}, {31'd0, ev});
      chk(gapped ? "gap_dout" : "seq_dout", dout_a, hold);
    end
  endtask

  initial begin
    logic signed [31:0] hold;
    tbl[0] = '{-12'sd1, 1'b0,  12'sd0, 1'b0};
    tbl[1] = '{-12'sd1, 1'b0,  12'sd0, 1'b0};
    tbl[2] = '{-12'sd1, 1'b0,  12'sd0, 1'b0};
    tbl[3] = '{ 12'sd0, 1'b1, -12'sd1, 1'b1};
    tbl[4] = '{ 12'sd0, 1'b1, -12'sd1, 1'b1};
    tbl[5] = '{ 12'sd0, 1'b1, -12'sd1, 1'b1};
    tbl[6] = '{ 12'sd0, 1'b1,  12'sd0, 1'b1};

    // Reset state of both instances
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    chk("rst_dout", dout_a, 0);
    chk("rst_vld", {31'd0, dv_a}, 0);
    chk("rst_filled", {31'd0, filled_a}, 0);
    chk("rst_b_dout", dout_b, 0);

    // N=4 floor rounding table
    foreach (tbl[i]) begin
      vld_b = 1'b1; din_b = tbl[i].din;
      @(posedge clk); #1;
      vld_b = 1'b0;
      chk("n4_vld", {31'd0, dv_b}, {31'd0, tbl[i].v});
      chk("n4_dout", dout_b, tbl[i].d);
      chk("n4_filled", {31'd0, filled_b}, {31'd0, tbl[i].f});
    end

    // DECIM=1, constant 100
    decim_a = 8'd1;
    reset_a();
    for (int i = 1; i <= 20; i++) begin
      step_a(1'b1, 12'sd100);
      chk("c100_vld", {31'd0, dv_a}, {31'd0, (i >= 16)});
      chk("c100_dout", dout_a, (i >= 16) ? 100 : 0);
      chk("c100_filled", {31'd0, filled_a}, {31'd0, (i >= 16)});
    end

    // DECIM=4, ramp: emissions at samples 16, 20, 24
    decim_a = 8'd4;
    reset_a();
    hold = 0;
    for (int j = 1; j <= 25; j++) begin
      step_a(1'b1, 12'(j - 1));
      if (j == 16 || j == 20 || j == 24) hold = j - 9;
      chk("ramp_vld", {31'd0, dv_a}, {31'd0, (j == 16 || j == 20 || j == 24)});
      chk("ramp_dout", dout_a, hold);
    end

    // Full scale, DECIM=1
    decim_a = 8'd1;
    reset_a();
    repeat (16) step_a(1'b1, 12'sd2047);
    chk("fs_pos_dout", dout_a, 2047);
    chk("fs_pos_vld", {31'd0, dv_a}, 1);
    for (int k = 1; k <= 16; k++) begin
      step_a(1'b1, -12'sd2048);
      if (k == 8) chk("fs_mid_dout", dout_a, -1);
    end
    chk("fs_neg_dout", dout_a, -2048);
    chk("fs_neg_vld", {31'd0, dv_a}, 1);

    // DECIM=0 acts as 1
    decim_a = 8'd0;
    reset_a();
    for (int i = 1; i <= 19; i++) begin
      step_a(1'b1, 12'sd5);
      chk("d0_vld", {31'd0, dv_a}, {31'd0, (i >= 16)});
    end
    chk("d0_dout", dout_a, 5);

    // DECIM 1->3 mid-stream, ungapped and gapped give the same stream
    run_seq(1'b0);
    run_seq(1'b1);

    // Reset mid-stream with din_valid asserted
    decim_a = 8'd1;
    reset_a();
    repeat (26) step_a(1'b1, 12'sd300);
    chk("mr_pre_dout", dout_a, 300);
    reset_a();
    chk("mr_dout", dout_a, 0);
    chk("mr_vld", {31'd0, dv_a}, 0);
    chk("mr_filled", {31'd0, filled_a}, 0);
    for (int i = 1; i <= 16; i++) begin
      step_a(1'b1, 12'sd50);
      chk("mr_vld_post", {31'd0, dv_a}, {31'd0, (i == 16)});
    end
    chk("mr_dout_post", dout_a, 50);
    chk("mr_filled_post", {31'd0, filled_a}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
